// File: rtl/mem_resp_pkg.sv
// Shared CPU constants: opcode definitions plus the data-memory responder FSM encodings
// and the address-check helper used by mem_resp.
package mem_resp_pkg;

    typedef enum logic [6:0] {
        OpLoad   = 7'b0000011,
        OpStore  = 7'b0100011,
        OpImm    = 7'b0010011,
        OpReg    = 7'b0110011,
        OpBranch = 7'b1100011,
        OpJal    = 7'b1101111
    } opcode_e;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StResp = 2'd2
    } mem_state_e;

    localparam int unsigned WaitCntW = 4;

    // Misaligned or beyond the last stored word.
    function automatic logic addr_err(input logic [31:0] addr, input int unsigned depth_words);
        return (addr[1:0] != 2'b00) || ((addr >> 2) >= depth_words);
    endfunction

endpackage

// File: rtl/mem_resp_if.sv
// Request/response handshake bundle between a data-memory initiator and mem_resp.
interface mem_resp_if;

    logic        req_valid;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        req_ready;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/mem_resp_array.sv
// Single-port word storage: byte-enabled synchronous write, combinational read, no reset.
module mem_resp_array #(
    parameter int unsigned DEPTH_WORDS = 1024,
    localparam int unsigned AddrW = $clog2(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AddrW-1:0] addr,
    input  logic [31:0]      wdata,
    input  logic [3:0]       be,
    output logic [31:0]      rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/mem_resp.sv
// Data-memory responder: accepts one request at a time, inserts WAIT_CYCLES wait states,
// checks alignment/range and holds the response until the initiator takes it.
module mem_resp
    import mem_resp_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic      clk,
    input  logic      rst,
    mem_resp_if.slave bus
);

    localparam int unsigned AddrW = $clog2(DEPTH_WORDS);

    mem_state_e          state_q, state_d;
    logic [WaitCntW-1:0] cnt_q, cnt_d;
    logic [31:0]         addr_q, wdata_q;
    logic [3:0]          be_q;
    logic                we_q;

    logic        accept;
    logic        commit;
    logic [31:0] cur_addr, cur_wdata;
    logic [3:0]  cur_be;
    logic        cur_we;
    logic        cur_err;
    logic        err_q;
    logic [31:0] mem_rdata;

    assign accept = (state_q == StIdle) && bus.req_valid;

    // With zero wait states the write commits on the accepting edge, before the latches load.
    assign cur_addr  = (state_q == StIdle) ? bus.req_addr  : addr_q;
    assign cur_wdata = (state_q == StIdle) ? bus.req_wdata : wdata_q;
    assign cur_be    = (state_q == StIdle) ? bus.req_be    : be_q;
    assign cur_we    = (state_q == StIdle) ? bus.req_we    : we_q;
    assign cur_err   = addr_err(cur_addr, DEPTH_WORDS);
    assign err_q     = addr_err(addr_q, DEPTH_WORDS);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (bus.req_valid) begin
                    if (WAIT_CYCLES == 0) begin
                        state_d = StResp;
                    end else begin
                        state_d = StWait;
                        cnt_d   = WaitCntW'(WAIT_CYCLES - 1);
                    end
                end
            end
            StWait: begin
                if (cnt_q == '0) begin
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StResp: begin
                if (bus.rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Storage only changes on the edge entering RESP, so an aborted WAIT never writes.
    assign commit = (state_d == StResp) && (state_q != StResp) && cur_we && !cur_err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
                be_q    <= bus.req_be;
                we_q    <= bus.req_we;
            end
        end
    end

    mem_resp_array #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_array (
        .clk  (clk),
        .we   (commit),
        .addr (cur_addr[AddrW+1:2]),
        .wdata(cur_wdata),
        .be   (cur_be),
        .rdata(mem_rdata)
    );

    always_comb begin
        bus.req_ready = (state_q == StIdle);
        bus.rsp_valid = (state_q == StResp);
        bus.rsp_err   = bus.rsp_valid && err_q;
        bus.rsp_rdata = (bus.rsp_valid && !we_q && !err_q) ? mem_rdata : 32'h0;
    end

endmodule

// File: tb/tb_mem_resp.sv
// Directed bench for mem_resp: three instances (0/1/3 wait states) share one stimulus bus,
// with a queue of expected responses built from a byte-lane memory model.
module tb_mem_resp;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  sel = 2'd1;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_be = '0;
    logic        rsp_ready = 1'b0;

    logic        o_req_ready, o_rsp_valid, o_rsp_err;
    logic [31:0] o_rsp_rdata;

    int n_cmp = 0;
    int n_fail = 0;
    int unsigned cyc = 0;
    int unsigned last_acc = 0;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] model [int unsigned];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_resp_if bus0 ();
    mem_resp_if bus1 ();
    mem_resp_if bus2 ();

    assign bus0.req_valid = req_valid && (sel == 2'd0);
    assign bus1.req_valid = req_valid && (sel == 2'd1);
    assign bus2.req_valid = req_valid && (sel == 2'd2);
    assign bus0.rsp_ready = rsp_ready && (sel == 2'd0);
    assign bus1.rsp_ready = rsp_ready && (sel == 2'd1);
    assign bus2.rsp_ready = rsp_ready && (sel == 2'd2);
    assign bus0.req_we = req_we;
    assign bus1.req_we = req_we;
    assign bus2.req_we = req_we;
    assign bus0.req_addr = req_addr;
    assign bus1.req_addr = req_addr;
    assign bus2.req_addr = req_addr;
    assign bus0.req_wdata = req_wdata;
    assign bus1.req_wdata = req_wdata;
    assign bus2.req_wdata = req_wdata;
    assign bus0.req_be = req_be;
    assign bus1.req_be = req_be;
    assign bus2.req_be = req_be;

    always_comb begin
        o_req_ready = bus1.req_ready;
        o_rsp_valid = bus1.rsp_valid;
        o_rsp_rdata = bus1.rsp_rdata;
        o_rsp_err   = bus1.rsp_err;
        case (sel)
            2'd0: begin
                o_req_ready = bus0.req_ready;
                o_rsp_valid = bus0.rsp_valid;
                o_rsp_rdata = bus0.rsp_rdata;
                o_rsp_err   = bus0.rsp_err;
            end
            2'd2: begin
                o_req_ready = bus2.req_ready;
                o_rsp_valid = bus2.rsp_valid;
                o_rsp_rdata = bus2.rsp_rdata;
                o_rsp_err   = bus2.rsp_err;
            end
            default: ;
        endcase
    end

    mem_resp #(.DEPTH_WORDS(16),   .WAIT_CYCLES(0)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
    mem_resp #(.DEPTH_WORDS(1024), .WAIT_CYCLES(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
    mem_resp #(.DEPTH_WORDS(1024), .WAIT_CYCLES(3)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic model_err(input logic [31:0] addr);
        int unsigned depth = (sel == 2'd0) ? 16 : 1024;
        return (addr[1:0] != 2'b00) || (int'(addr[31:2]) >= int'(depth)) || (addr[31:12] != 0 && depth == 1024);
    endfunction

    // Entered and left at a falling edge; hold = extra cycles of rsp_ready=0 in RESP.
    task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, input int lat, input int hold, input int gap);
        exp_t        e;
        int unsigned key;
        logic [31:0] w;
        int          k;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_be    = be;
        req_valid = 1'b1;
        rsp_ready = (hold == 0);
        check("req_ready_before_accept", 32'(o_req_ready), 32'd1);
        e.err   = model_err(addr);
        e.rdata = 32'h0;
        key     = 32'(sel) * 65536 + 32'(addr[31:2]);
        if (!e.err) begin
            w = model.exists(key) ? model[key] : 32'h0;
            if (we) begin
                for (int i = 0; i < 4; i++) begin
                    if (be[i]) w[8*i +: 8] = wdata[8*i +: 8];
                end
                model[key] = w;
            end else begin
                e.rdata = w;
            end
        end
        exp_q.push_back(e);
        @(negedge clk);
        req_valid = 1'b0;
        req_we    = ~we;
        req_addr  = 32'h0000_0004;
        req_wdata = 32'h5A5A_5A5A;
        req_be    = 4'hF;
        if (gap > 0) check("accept_gap", cyc - last_acc, 32'(gap));
        last_acc = cyc;
        k = 0;
        while (o_rsp_valid !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("latency", 32'(k), 32'(lat));
        e = exp_q.pop_front();
        check("rsp_rdata", o_rsp_rdata, e.rdata);
        check("rsp_err", 32'(o_rsp_err), 32'(e.err));
        for (int i = 0; i < hold; i++) begin
            req_valid = i[0];
            @(negedge clk);
            check("hold_rsp_valid", 32'(o_rsp_valid), 32'd1);
            check("hold_rsp_rdata", o_rsp_rdata, e.rdata);
            check("hold_rsp_err", 32'(o_rsp_err), 32'(e.err));
            check("hold_req_ready", 32'(o_req_ready), 32'd0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        check("idle_rsp_valid", 32'(o_rsp_valid), 32'd0);
        check("idle_rsp_rdata", o_rsp_rdata, 32'h0);
        check("idle_rsp_err", 32'(o_rsp_err), 32'd0);
        check("idle_req_ready", 32'(o_req_ready), 32'd1);
        rsp_ready = 1'b0;
    endtask

    initial begin
        #2;
        for (int s = 0; s < 3; s++) begin
            sel = 2'(s);
            #1;
            check("reset_rsp_valid", 32'(o_rsp_valid), 32'd0);
            check("reset_rsp_rdata", o_rsp_rdata, 32'h0);
            check("reset_rsp_err", 32'(o_rsp_err), 32'd0);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("reset_req_ready", 32'(o_req_ready), 32'd1);

        // One wait state, 1024 words.
        sel = 2'd1;
        txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1, 0, 0);
        txn(1'b0, 32'h10, 32'h0, 4'h0, 1, 0, 3);
        txn(1'b1, 32'h20, 32'h11223344, 4'hF, 1, 0, 0);
        txn(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 1, 0, 0);
        txn(1'b0, 32'h20, 32'h0, 4'h0, 1, 0, 0);
        check("byte_lane_model", model[32'd65536 + 32'd8], 32'h11BB33DD);
        txn(1'b1, 32'h0, 32'hCAFEF00D, 4'hF, 1, 0, 0);
        txn(1'b0, 32'h22, 32'h0, 4'h0, 1, 0, 0);
        txn(1'b1, 32'h1000, 32'hFFFFFFFF, 4'hF, 1, 0, 0);
        txn(1'b0, 32'h0, 32'h0, 4'h0, 1, 0, 0);
        txn(1'b1, 32'hFFC, 32'h0BADCAFE, 4'hF, 1, 0, 0);
        txn(1'b0, 32'hFFC, 32'h0, 4'h0, 1, 0, 0);
        txn(1'b1, 32'h10, 32'h01234567, 4'h0, 1, 0, 0);
        txn(1'b0, 32'h10, 32'h0, 4'h0, 1, 0, 0);
        txn(1'b0, 32'h20, 32'h0, 4'h0, 1, 5, 0);

        // Zero wait states, 16 words: back-to-back accepts every second cycle.
        sel = 2'd0;
        txn(1'b1, 32'h3C, 32'h12345678, 4'hF, 0, 0, 0);
        txn(1'b0, 32'h3C, 32'h0, 4'h0, 0, 0, 2);
        txn(1'b1, 32'h7C, 32'hFFFFFFFF, 4'hF, 0, 0, 2);
        txn(1'b0, 32'h3C, 32'h0, 4'h0, 0, 0, 2);
        txn(1'b0, 32'h40, 32'h0, 4'h0, 0, 0, 2);

        // Three wait states: reset during WAIT aborts the pending write.
        sel = 2'd2;
        txn(1'b1, 32'h30, 32'h01020304, 4'hF, 3, 0, 0);
        req_we    = 1'b1;
        req_addr  = 32'h30;
        req_wdata = 32'h55AA55AA;
        req_be    = 4'hF;
        req_valid = 1'b1;
        check("abort_req_ready", 32'(o_req_ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort_rsp_valid", 32'(o_rsp_valid), 32'd0);
        check("abort_rsp_rdata", o_rsp_rdata, 32'h0);
        check("abort_rsp_err", 32'(o_rsp_err), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("abort_no_response", 32'(o_rsp_valid), 32'd0);
        end
        txn(1'b0, 32'h30, 32'h0, 4'h0, 3, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
